conv_ofmap_writer: RTL and testbench

- Output-side writeback engine for the 3x5 row-stationary PE array. Receives one output row per handshake as FIL_S rows of DO_W partial sums, one per PE row.
- Adds the PE-row psums column-wise with Q(INWIDTH-IN_FRAC).IN_FRAC saturation and buffers whole rows.
- Writes the DO_W x DO_H output map back to DRAM one word per cycle over a valid/ready write port, then pulses done.
- It is the DRAM-write counterpart of the array's input-read path.

---
 rtl/conv_ofmap_writer.sv | 187 ++++++++++++++++++
 tb/tb_conv_ofmap_writer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ofmap_writer.sv
// Output-map writeback engine: sums PE-row psums per column with saturation,
// buffers whole rows and streams them to DRAM one word per cycle.
module conv_ofmap_writer #(
  parameter int unsigned INWIDTH    = 16,
  parameter int unsigned IN_FRAC    = 12,
  parameter int unsigned FIL_S      = 3,
  parameter int unsigned DO_W       = 5,
  parameter int unsigned DO_H       = 5,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             row_valid,
  output logic                             row_ready,
  input  logic [FIL_S*DO_W*INWIDTH-1:0]    psum_in,
  output logic                             mem_we,
  input  logic                             mem_ready,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [INWIDTH-1:0]               mem_wdata,
  output logic                             busy,
  output logic                             done,
  output logic                             ovf_flag
);

  localparam int unsigned SUM_W = INWIDTH + 2;
  localparam int unsigned ROW_W = DO_W * INWIDTH;
  localparam int unsigned WORDS = DO_W * DO_H;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RIN_W = $clog2(DO_H + 1);
  localparam int unsigned WO_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned COL_W = (DO_W > 1) ? $clog2(DO_W) : 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(INWIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(INWIDTH-1){1'b0}}};

  // The fixed-point format is passed through untouched; only sanity-check it.
  if (IN_FRAC >= INWIDTH) begin : g_bad_frac
    $error("IN_FRAC must be smaller than INWIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ROW_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        fifo_cnt_q;
  logic [RIN_W-1:0]        rows_in_q;
  logic [WO_W-1:0]         words_out_q;
  logic [COL_W-1:0]        col_q;
  logic [ROW_W-1:0]        row_sr_q;
  logic                    wr_valid_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    ovf_q;

  logic                    start, row_fire, wr_fire, last_col, pop;
  logic [ROW_W-1:0]        sum_row;
  logic                    any_sat;
  logic signed [SUM_W-1:0] acc;
  logic [INWIDTH-1:0]      elem;

  assign start     = (state_q == StIdle) && en;
  assign row_ready = (state_q == StRun) && (fifo_cnt_q < CNT_W'(FIFO_DEPTH)) &&
                     (rows_in_q < RIN_W'(DO_H));
  assign row_fire  = row_valid && row_ready;
  assign wr_fire   = wr_valid_q && mem_ready;
  assign last_col  = (col_q == COL_W'(DO_W - 1));
  // Reload at the same edge as the last column's accept so streaming has no bubble.
  assign pop       = (state_q == StRun) && (fifo_cnt_q != '0) &&
                     (!wr_valid_q || (wr_fire && last_col));

  assign mem_we    = wr_valid_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = row_sr_q[INWIDTH-1:0];
  assign ovf_flag  = ovf_q;

  // Column-wise sign-extended psum sum with clamp to the INWIDTH range.
  always_comb begin
    sum_row = '0;
    any_sat = 1'b0;
    acc     = '0;
    elem    = '0;
    for (int c = 0; c < DO_W; c++) begin
      acc = '0;
      for (int r = 0; r < FIL_S; r++) begin
        elem = psum_in[(r*DO_W+c)*INWIDTH +: INWIDTH];
        acc  = acc + {{2{elem[INWIDTH-1]}}, elem};
      end
      if (acc > SAT_MAX) begin
        sum_row[c*INWIDTH +: INWIDTH] = {1'b0, {(INWIDTH-1){1'b1}}};
        any_sat = 1'b1;
      end else if (acc < SAT_MIN) begin
        sum_row[c*INWIDTH +: INWIDTH] = {1'b1, {(INWIDTH-1){1'b0}}};
        any_sat = 1'b1;
      end else begin
        sum_row[c*INWIDTH +: INWIDTH] = acc[INWIDTH-1:0];
      end
    end
  end

  // FSM next state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: if (en) state_d = StRun;
      StRun: begin
        busy = 1'b1;
        if (wr_fire && (words_out_q == WO_W'(WORDS - 1))) state_d = StDone;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Row storage; contents are don't-care while the occupancy count is zero.
  always_ff @(posedge clk) begin
    if (row_fire) fifo_mem[wr_ptr_q] <= sum_row;
  end

  // FIFO pointers, counters, writer shift register and address generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      rows_in_q   <= '0;
      words_out_q <= '0;
      col_q       <= '0;
      row_sr_q    <= '0;
      wr_valid_q  <= 1'b0;
      addr_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (start) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      rows_in_q   <= '0;
      words_out_q <= '0;
      col_q       <= '0;
      wr_valid_q  <= 1'b0;
      addr_q      <= ADDR_W'(BASE_ADDR);
      ovf_q       <= 1'b0;
    end else begin
      if (row_fire) begin
        wr_ptr_q  <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        rows_in_q <= rows_in_q + 1'b1;
        if (any_sat) ovf_q <= 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (row_fire && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!row_fire && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;

      if (wr_fire) begin
        words_out_q <= words_out_q + 1'b1;
        addr_q      <= addr_q + 1'b1;
      end
      if (pop) begin
        row_sr_q   <= fifo_mem[rd_ptr_q];
        wr_valid_q <= 1'b1;
        col_q      <= '0;
      end else if (wr_fire) begin
        if (last_col) begin
          wr_valid_q <= 1'b0;
        end else begin
          row_sr_q <= row_sr_q >> INWIDTH;
          col_q    <= col_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_ofmap_writer.sv
// Scoreboard bench for conv_ofmap_writer: a row-level reference model queues
// expected (addr, data) words; an independent monitor checks every DRAM write.
module tb_conv_ofmap_writer;

  localparam int W     = 16;
  localparam int FS    = 3;
  localparam int DW    = 5;
  localparam int DH    = 5;
  localparam int AW    = 8;
  localparam int BASE  = 0;
  localparam int DEPTH = 2;
  localparam int PW    = FS * DW * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          row_valid = 1'b0;
  logic          mem_ready = 1'b1;
  logic [PW-1:0] psum_in = '0;
  logic          row_ready, mem_we, busy, done, ovf_flag;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;

  conv_ofmap_writer #(
    .INWIDTH(W), .IN_FRAC(12), .FIL_S(FS), .DO_W(DW), .DO_H(DH),
    .ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .row_valid(row_valid), .row_ready(row_ready),
    .psum_in(psum_in), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [AW+W-1:0] sb[$];
  int            exp_row = 0;
  bit            exp_ovf = 1'b0;
  int            wr_count = 0;
  bit            force_low = 1'b0;
  bit            rand_ready = 1'b0;
  int            stall_addr = -1;
  int            stall_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer column sums, clamped, addressed row-major from BASE.
  task automatic model_row(input logic [PW-1:0] v);
    int s;
    for (int c = 0; c < DW; c++) begin
      s = 0;
      for (int r = 0; r < FS; r++) s += int'($signed(v[(r*DW+c)*W +: W]));
      if (s > 32767) begin
        s = 32767;
        exp_ovf = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        exp_ovf = 1'b1;
      end
      sb.push_back({AW'(BASE + exp_row * DW + c), s[W-1:0]});
    end
    exp_row++;
  endtask

  function automatic logic [PW-1:0] uniform_row(input logic [W-1:0] val);
    return {(FS*DW){val}};
  endfunction

  function automatic logic [PW-1:0] rand_row();
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < FS * DW; i++)
      v[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) :
                                                  W'($urandom_range(0, 8191) - 4096);
    return v;
  endfunction

  // Offer a row for up to budget cycles; expected words are queued on acceptance.
  task automatic offer_row(input logic [PW-1:0] v, input int budget, output bit acc);
    row_valid = 1'b1;
    psum_in   = v;
    acc       = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (row_ready) begin
        model_row(v);
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    row_valid = 1'b0;
  endtask

  task automatic start_map();
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    en       = 1'b0;
    exp_row  = 0;
    exp_ovf  = 1'b0;
    wr_count = 0;
    @(negedge clk);
    check("busy_after_en", busy, 1);
    check("ovf_cleared_on_en", ovf_flag, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, seen, 1);
    if (seen) begin
      check({name, "_all_words_written"}, sb.size(), 0);
      check({name, "_ovf"}, ovf_flag, exp_ovf);
      @(negedge clk);
      check({name, "_done_one_cycle_busy_low"}, {done, busy}, 2'b00);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    check(name, {row_ready, mem_we, mem_addr, mem_wdata, busy, done, ovf_flag}, 0);
  endtask

  // DRAM-side ready generator: forced low, targeted stall, random or always ready.
  initial forever begin
    @(posedge clk); #2;
    if (force_low) mem_ready = 1'b0;
    else if (stall_left > 0 && mem_we && int'(mem_addr) == stall_addr) begin
      mem_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    else mem_ready = 1'b1;
  end

  // Monitor: every accepted write must match the scoreboard head; stalled words must hold.
  initial begin
    logic [AW+W-1:0] e;
    bit              hold_pend;
    logic [AW-1:0]   hold_addr;
    logic [W-1:0]    hold_data;
    hold_pend = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend)
          check("stall_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, hold_addr, hold_data});
        if (mem_we && mem_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_write", {mem_addr, mem_wdata}, 'x);
          end else begin
            e = sb.pop_front();
            check("write_addr_data", {mem_addr, mem_wdata}, e);
          end
          wr_count++;
        end
        hold_pend = mem_we && !mem_ready;
        hold_addr = mem_addr;
        hold_data = mem_wdata;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit            acc;
    int            cnt;
    logic [PW-1:0] v;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. Nominal map, first-row latency
    start_map();
    offer_row(uniform_row(16'h1000), 50, acc);
    check("nominal_row0_accepted", acc, 1);
    @(negedge clk);
    check("latency_no_we_at_t", mem_we, 0);
    @(negedge clk);
    check("latency_we_after_t1", mem_we, 1);
    @(posedge clk); #1;
    for (int i = 1; i < DH; i++) offer_row(uniform_row(16'h1000), 200, acc);
    wait_done("nominal");

    // 2. Backpressure with a 3-cycle stall at addr 7, random ready elsewhere
    rand_ready = 1'b1;
    stall_addr = 7;
    stall_left = 3;
    start_map();
    for (int i = 0; i < DH; i++) offer_row(rand_row(), 300, acc);
    wait_done("backpressure");
    check("stall_at_addr7_exercised", stall_left, 0);
    stall_addr = -1;

    // 3. Saturation
    rand_ready = 1'b0;
    start_map();
    v = '0;
    for (int c = 0; c < DW; c++) begin
      v[(0*DW+c)*W +: W] = 16'h1000;
      v[(1*DW+c)*W +: W] = 16'hF000;
      v[(2*DW+c)*W +: W] = 16'h0001;
    end
    offer_row(v, 50, acc);
    check("mixed_no_ovf", ovf_flag, 0);
    offer_row(uniform_row(16'h7000), 200, acc);
    check("pos_sat_sets_ovf", ovf_flag, 1);
    offer_row(uniform_row(16'h9000), 200, acc);
    for (int i = 3; i < DH; i++) offer_row(rand_row(), 200, acc);
    wait_done("saturation");
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ovf_held_in_idle", ovf_flag, 1);
    @(posedge clk); #1;

    // 4. Buffer full under permanent backpressure
    force_low = 1'b1;
    start_map();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      offer_row(rand_row(), 15, acc);
      if (acc) cnt++;
    end
    check("full_rows_accepted", cnt, 3);
    @(negedge clk);
    check("full_row_ready_low", row_ready, 0);
    @(posedge clk); #1;
    force_low = 1'b0;
    for (int i = 3; i < DH; i++) offer_row(rand_row(), 300, acc);
    wait_done("buffer_full");

    // 5. Reset after 7 accepted writes, then a clean map
    start_map();
    for (int i = 0; i < 2; i++) offer_row(rand_row(), 50, acc);
    cnt = 0;
    while (wr_count < 7 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("seven_writes_before_reset", wr_count, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrun_reset_outputs");
    sb.delete();
    @(posedge clk); #1;
    start_map();
    for (int i = 0; i < DH; i++) offer_row(rand_row(), 200, acc);
    wait_done("after_reset");

    // 6. Protocol guards
    row_valid = 1'b1;
    psum_in   = rand_row();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_row_ready_low", row_ready, 0);
    end
    @(posedge clk); #1;
    row_valid = 1'b0;
    start_map();
    for (int i = 0; i < 2; i++) offer_row(rand_row(), 200, acc);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    check("en_in_run_keeps_busy", busy, 1);
    @(posedge clk); #1;
    for (int i = 2; i < DH; i++) offer_row(rand_row(), 200, acc);
    force_low = 1'b1;
    offer_row(rand_row(), 20, acc);
    check("sixth_row_rejected", acc, 0);
    force_low = 1'b0;
    wait_done("guards");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
